// File: rtl/uart_baud_tick_gen.sv
// Fractional-N baud tick generator shared by UART TX and RX.
// Produces an OVERSAMPLE x baud sample tick plus mid-bit and bit-boundary ticks.
module uart_baud_tick_gen #(
  parameter int unsigned SYS_CLK_FREQ = 200_000_000,
  parameter int unsigned BAUD_RATE    = 19200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_INT_W    = 16,
  parameter int unsigned DIV_FRAC_W   = 4
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [DIV_INT_W-1:0]          div_int,
  input  logic [DIV_FRAC_W-1:0]         div_frac,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          sample_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_idx,
  output logic                          cfg_err
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = DIV_INT_W + 1;

  // Reset divisor rounded to nearest in units of 1/2^DIV_FRAC_W sys_clk cycles.
  localparam logic [63:0] DEF_NUM  = 64'(SYS_CLK_FREQ) << DIV_FRAC_W;
  localparam logic [63:0] DEF_DEN  = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_DIV  = (DEF_NUM + (DEF_DEN >> 1)) / DEF_DEN;
  localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DEF_DIV[DIV_FRAC_W-1:0];
  localparam logic [DIV_INT_W-1:0]  DEF_INT  = DEF_DIV[DIV_FRAC_W +: DIV_INT_W];

  localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);

  logic [DIV_INT_W-1:0]  curInt_q,  curInt_d;
  logic [DIV_FRAC_W-1:0] curFrac_q, curFrac_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q,     acc_d;
  logic                  extra_q,   extra_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  enDly_q;
  logic                  sampleTick_q, sampleTick_d;
  logic                  midTick_q,    midTick_d;
  logic                  bitTick_q,    bitTick_d;
  logic                  cfgErr_q,     cfgErr_d;

  logic                  loadOk;
  logic                  loadBad;
  logic                  phaseClear;
  logic                  term;
  logic                  tickNow;
  logic [CNT_W-1:0]      termCnt;
  logic [DIV_FRAC_W:0]   fracSum;

  // The first enabled cycle acts as a phase clear, so a rising enable
  // behaves like resync and the first tick lands cur_int+1 cycles out.
  always_comb begin
    loadOk     = div_load && (div_int >= DIV_INT_W'(2));
    loadBad    = div_load && (div_int <  DIV_INT_W'(2));
    phaseClear = !enable || !enDly_q || loadOk || resync;
    termCnt    = CNT_W'(curInt_q) - CNT_W'(1) + CNT_W'(extra_q);
    term       = enable && (cnt_q == termCnt);
    tickNow    = term && !phaseClear;
    fracSum    = {1'b0, acc_q} + {1'b0, curFrac_q};

    curInt_d     = curInt_q;
    curFrac_d    = curFrac_q;
    cnt_d        = cnt_q + CNT_W'(1);
    acc_d        = acc_q;
    extra_d      = extra_q;
    idx_d        = idx_q;
    sampleTick_d = tickNow;
    midTick_d    = tickNow && (idx_q == MID_IDX);
    bitTick_d    = tickNow && (idx_q == LAST_IDX);
    cfgErr_d     = loadBad;

    if (loadOk) begin
      curInt_d  = div_int;
      curFrac_d = div_frac;
    end

    if (phaseClear) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      idx_d   = '0;
    end else if (term) begin
      cnt_d   = '0;
      acc_d   = fracSum[DIV_FRAC_W-1:0];
      extra_d = fracSum[DIV_FRAC_W];
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      curInt_q     <= DEF_INT;
      curFrac_q    <= DEF_FRAC;
      cnt_q        <= '0;
      acc_q        <= '0;
      extra_q      <= 1'b0;
      idx_q        <= '0;
      enDly_q      <= 1'b0;
      sampleTick_q <= 1'b0;
      midTick_q    <= 1'b0;
      bitTick_q    <= 1'b0;
      cfgErr_q     <= 1'b0;
    end else begin
      curInt_q     <= curInt_d;
      curFrac_q    <= curFrac_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      extra_q      <= extra_d;
      idx_q        <= idx_d;
      enDly_q      <= enable;
      sampleTick_q <= sampleTick_d;
      midTick_q    <= midTick_d;
      bitTick_q    <= bitTick_d;
      cfgErr_q     <= cfgErr_d;
    end
  end

  assign sample_tick = sampleTick_q;
  assign mid_tick    = midTick_q;
  assign bit_tick    = bitTick_q;
  assign sample_idx  = idx_q;
  assign cfg_err     = cfgErr_q;

endmodule
